// File: rtl/vec_add_sat_acc_pkg.sv
// Shared definitions for the saturating vector adder/accumulator:
// operation encodings and the signed saturation limits for a given width.
package vec_add_pkg;

  typedef enum logic [1:0] {
    MODE_ADD  = 2'd0,
    MODE_SUB  = 2'd1,
    MODE_ACC  = 2'd2,
    MODE_LOAD = 2'd3
  } mode_e;

  // Largest representable value of a dw-bit two's complement number.
  function automatic longint sat_max(input int dw);
    return (64'sd1 <<< (dw - 1)) - 64'sd1;
  endfunction

  // Most negative representable value of a dw-bit two's complement number.
  function automatic longint sat_min(input int dw);
    return -(64'sd1 <<< (dw - 1));
  endfunction

endpackage

// File: rtl/vec_add_sat_acc_if.sv
// Input and result stream of the vector adder, grouped as one bundle.
// The slave modport is the datapath's view, master the producer/consumer's.
interface vec_add_sat_acc_if #(
  parameter int LANES = 16,
  parameter int DW    = 16
) ();
  import vec_add_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  mode_e                 mode;
  logic [LANES*DW-1:0]   a;
  logic [LANES*DW-1:0]   b;
  logic                  out_valid;
  logic                  out_ready;
  logic [LANES*DW-1:0]   sum;
  logic [LANES-1:0]      sat;

  modport slave (
    input  in_valid, mode, a, b, out_ready,
    output in_ready, out_valid, sum, sat
  );

  modport master (
    output in_valid, mode, a, b, out_ready,
    input  in_ready, out_valid, sum, sat
  );

endinterface

// File: rtl/vec_add_sat_acc_lane.sv
// One lane: signed add or subtract at full DW+1 precision, then clip back
// to DW bits. sat flags that clipping happened.
module vec_add_lane
  import vec_add_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic [DW-1:0] x,
  input  logic [DW-1:0] y,
  input  logic          sub,
  output logic [DW-1:0] r,
  output logic          sat
);

  localparam logic [DW-1:0] POS_LIM = DW'(sat_max(DW));
  localparam logic [DW-1:0] NEG_LIM = DW'(sat_min(DW));

  logic signed [DW:0] x_ext_s;
  logic signed [DW:0] y_ext_s;
  logic signed [DW:0] full_s;

  // Widen by one bit so the raw result never wraps; a mismatch between the
  // top two bits then means it does not fit in DW bits and must be clipped.
  always_comb begin
    x_ext_s = $signed({x[DW-1], x});
    y_ext_s = $signed({y[DW-1], y});
    if (sub) begin
      full_s = x_ext_s - y_ext_s;
    end else begin
      full_s = x_ext_s + y_ext_s;
    end
    if (full_s[DW] != full_s[DW-1]) begin
      sat = 1'b1;
      r   = full_s[DW] ? NEG_LIM : POS_LIM;
    end else begin
      sat = 1'b0;
      r   = full_s[DW-1:0];
    end
  end

endmodule

// File: rtl/vec_add_sat_acc.sv
// LANES-wide saturating add / subtract / accumulate with a one-stage
// registered valid/ready output. The per-lane accumulator is updated in the
// same edge a beat is accepted, so back-to-back ACC beats chain directly.
module vec_add_sat_acc
  import vec_add_pkg::*;
#(
  parameter int LANES = 16,
  parameter int DW    = 16
) (
  input logic              clk,
  input logic              rst,
  vec_add_sat_acc_if.slave bus
);

  logic [LANES*DW-1:0] acc_r;
  logic [LANES*DW-1:0] sum_r;
  logic [LANES-1:0]    sat_r;
  logic                out_valid_r;

  logic [LANES*DW-1:0] lane_x_s;
  logic [LANES*DW-1:0] lane_y_s;
  logic                lane_sub_s;
  logic [LANES*DW-1:0] res_s;
  logic [LANES-1:0]    res_sat_s;
  logic                in_xfer_s;
  logic                acc_wr_s;

  // The stage can take a beat when it is empty or its result leaves now.
  assign bus.in_ready = !out_valid_r || bus.out_ready;
  assign in_xfer_s    = bus.in_valid && bus.in_ready;
  assign acc_wr_s     = (bus.mode == MODE_ACC) || (bus.mode == MODE_LOAD);

  // Map every mode onto the lane adder: LOAD is a + 0, so it never clips.
  always_comb begin
    lane_x_s   = bus.a;
    lane_y_s   = bus.b;
    lane_sub_s = 1'b0;
    case (bus.mode)
      MODE_ADD: begin
        lane_x_s   = bus.a;
        lane_y_s   = bus.b;
        lane_sub_s = 1'b0;
      end
      MODE_SUB: begin
        lane_x_s   = bus.a;
        lane_y_s   = bus.b;
        lane_sub_s = 1'b1;
      end
      MODE_ACC: begin
        lane_x_s   = acc_r;
        lane_y_s   = bus.a;
        lane_sub_s = 1'b0;
      end
      MODE_LOAD: begin
        lane_x_s   = bus.a;
        lane_y_s   = '0;
        lane_sub_s = 1'b0;
      end
      default: begin
        lane_x_s   = bus.a;
        lane_y_s   = bus.b;
        lane_sub_s = 1'b0;
      end
    endcase
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    vec_add_lane #(.DW(DW)) u_lane (
      .x   (lane_x_s[i*DW +: DW]),
      .y   (lane_y_s[i*DW +: DW]),
      .sub (lane_sub_s),
      .r   (res_s[i*DW +: DW]),
      .sat (res_sat_s[i])
    );
  end

  // Output register, accumulator and valid flag; a stall holds everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      sum_r       <= '0;
      sat_r       <= '0;
      acc_r       <= '0;
    end else if (in_xfer_s) begin
      out_valid_r <= 1'b1;
      sum_r       <= res_s;
      sat_r       <= res_sat_s;
      if (acc_wr_s) begin
        acc_r <= res_s;
      end else begin
        acc_r <= acc_r;
      end
    end else if (out_valid_r && bus.out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.sum       = sum_r;
  assign bus.sat       = sat_r;

endmodule

// File: tb/tb_vec_add_sat_acc.sv
// Directed and randomised checks of vec_add_sat_acc: a 16x16 instance for
// the directed cases and backpressure, plus 1/4/64-lane DW=8 instances driven
// in lockstep against an integer reference model.
module tb_vec_add_sat_acc;
  import vec_add_pkg::*;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  vec_add_sat_acc_if #(.LANES(16), .DW(16)) bus ();
  vec_add_sat_acc_if #(.LANES(1),  .DW(8))  bus1 ();
  vec_add_sat_acc_if #(.LANES(4),  .DW(8))  bus4 ();
  vec_add_sat_acc_if #(.LANES(64), .DW(8))  bus64 ();

  vec_add_sat_acc #(.LANES(16), .DW(16)) dut   (.clk(clk), .rst(rst), .bus(bus));
  vec_add_sat_acc #(.LANES(1),  .DW(8))  dut1  (.clk(clk), .rst(rst), .bus(bus1));
  vec_add_sat_acc #(.LANES(4),  .DW(8))  dut4  (.clk(clk), .rst(rst), .bus(bus4));
  vec_add_sat_acc #(.LANES(64), .DW(8))  dut64 (.clk(clk), .rst(rst), .bus(bus64));

  always #5 clk = ~clk;

  // reference accumulator, one signed integer per lane
  int m_acc[64];

  task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int getf(input logic [1023:0] v, input int i, input int dw);
    logic [1023:0] t;
    int raw;
    t   = v >> (i * dw);
    raw = int'(t[15:0]) & ((1 << dw) - 1);
    if (raw >= (1 << (dw - 1))) raw = raw - (1 << dw);
    return raw;
  endfunction

  // Reference: plain integer arithmetic, clip to the signed range of dw bits.
  task automatic model_beat(input int md, input logic [1023:0] av, input logic [1023:0] bv,
                            input int dw, input int lanes,
                            output logic [1023:0] es, output logic [63:0] esat);
    int x, y, full, r, lo, hi;
    lo   = -(1 << (dw - 1));
    hi   = (1 << (dw - 1)) - 1;
    es   = '0;
    esat = '0;
    for (int i = 0; i < lanes; i++) begin
      x = getf(av, i, dw);
      y = getf(bv, i, dw);
      case (md)
        0:       full = x + y;
        1:       full = x - y;
        2:       full = m_acc[i] + x;
        default: full = x;
      endcase
      r = (full > hi) ? hi : ((full < lo) ? lo : full);
      esat[i] = (r != full);
      if (md >= 2) m_acc[i] = r;
      es = es | (1024'(r & ((1 << dw) - 1)) << (i * dw));
    end
  endtask

  function automatic logic [1023:0] rand_vec();
    logic [1023:0] v;
    for (int k = 0; k < 32; k++) v[k*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic sweep_drive(input logic v, input int md, input logic [1023:0] av,
                             input logic [1023:0] bv);
    bus1.in_valid  = v;  bus4.in_valid  = v;  bus64.in_valid  = v;
    bus1.mode  = mode_e'(md); bus4.mode = mode_e'(md); bus64.mode = mode_e'(md);
    bus1.a  = av[7:0];   bus4.a  = av[31:0];  bus64.a  = av[511:0];
    bus1.b  = bv[7:0];   bus4.b  = bv[31:0];  bus64.b  = bv[511:0];
  endtask

  task automatic sweep_check(input string tag, input logic ev, input logic [1023:0] es,
                             input logic [63:0] esat);
    chk({tag, "_v1"},  1024'(bus1.out_valid),  1024'(ev));
    chk({tag, "_v4"},  1024'(bus4.out_valid),  1024'(ev));
    chk({tag, "_v64"}, 1024'(bus64.out_valid), 1024'(ev));
    if (ev) begin
      chk({tag, "_s1"},   1024'(bus1.sum),  1024'(es[7:0]));
      chk({tag, "_s4"},   1024'(bus4.sum),  1024'(es[31:0]));
      chk({tag, "_s64"},  1024'(bus64.sum), 1024'(es[511:0]));
      chk({tag, "_f1"},   1024'(bus1.sat),  1024'(esat[0:0]));
      chk({tag, "_f4"},   1024'(bus4.sat),  1024'(esat[3:0]));
      chk({tag, "_f64"},  1024'(bus64.sat), 1024'(esat[63:0]));
    end
  endtask

  initial begin
    logic [255:0]  va, vb, exp_sum;
    logic [15:0]   chain_a[4];
    logic [15:0]   chain_s[4];
    logic          chain_f[4];
    logic [1023:0] es, sa, sb;
    logic [63:0]   esat;
    logic [255:0]  q_sum[$];
    logic [15:0]   q_sat[$];
    logic          m_ov, in_x, out_x, ev;
    int            sent, got, md;

    clk = 1'b0; tests = 0; fails = 0;
    foreach (m_acc[i]) m_acc[i] = 0;

    // ---- reset with in_valid held high ----
    rst = 1'b1;
    bus.in_valid = 1'b1; bus.mode = MODE_ADD; bus.out_ready = 1'b1;
    bus.a = 256'(rand_vec()); bus.b = 256'(rand_vec());
    sweep_drive(1'b1, 0, rand_vec(), rand_vec());
    bus1.out_ready = 1'b1; bus4.out_ready = 1'b1; bus64.out_ready = 1'b1;
    step(); step();
    chk("rst_out_valid", 1024'(bus.out_valid), 1024'(1'b0));
    chk("rst_sum",       1024'(bus.sum),       1024'(256'd0));
    chk("rst_sat",       1024'(bus.sat),       1024'(16'd0));
    rst = 1'b0; bus.in_valid = 1'b0;
    sweep_drive(1'b0, 0, '0, '0);
    step();
    chk("rst_in_ready",  1024'(bus.in_ready),  1024'(1'b1));
    chk("rst_idle_valid", 1024'(bus.out_valid), 1024'(1'b0));

    // ---- directed ADD ----
    va = '0; vb = '0;
    va[15:0] = 16'h0003; vb[15:0]  = 16'h0004;
    va[31:16] = 16'h7FFF; vb[31:16] = 16'h0001;
    va[47:32] = 16'h8000; vb[47:32] = 16'hFFFF;
    bus.a = va; bus.b = vb; bus.mode = MODE_ADD; bus.in_valid = 1'b1;
    step();
    exp_sum = '0;
    exp_sum[15:0] = 16'h0007; exp_sum[31:16] = 16'h7FFF; exp_sum[47:32] = 16'h8000;
    chk("add_valid", 1024'(bus.out_valid), 1024'(1'b1));
    chk("add_sum",   1024'(bus.sum),       1024'(exp_sum));
    chk("add_sat",   1024'(bus.sat),       1024'(16'h0006));

    // ---- directed SUB ----
    va = '0; vb = '0;
    va[15:0] = 16'h0000; vb[15:0]  = 16'h8000;
    va[31:16] = 16'h0005; vb[31:16] = 16'h0007;
    bus.a = va; bus.b = vb; bus.mode = MODE_SUB;
    step();
    exp_sum = '0;
    exp_sum[15:0] = 16'h7FFF; exp_sum[31:16] = 16'hFFFE;
    chk("sub_sum", 1024'(bus.sum), 1024'(exp_sum));
    chk("sub_sat", 1024'(bus.sat), 1024'(16'h0001));

    // ---- accumulate chain, one beat per cycle, all lanes alike ----
    chain_a[0] = 16'd10;   chain_s[0] = 16'd10;   chain_f[0] = 1'b0;
    chain_a[1] = 16'd5;    chain_s[1] = 16'd15;   chain_f[1] = 1'b0;
    chain_a[2] = 16'hFFFD; chain_s[2] = 16'd12;   chain_f[2] = 1'b0;
    chain_a[3] = 16'h7FFF; chain_s[3] = 16'h7FFF; chain_f[3] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.mode = (k == 0) ? MODE_LOAD : MODE_ACC;
      bus.a = {16{chain_a[k]}}; bus.b = 256'(rand_vec());
      #1;
      chk($sformatf("chain_in_ready%0d", k), 1024'(bus.in_ready), 1024'(1'b1));
      step();
      chk($sformatf("chain_sum%0d", k), 1024'(bus.sum), 1024'({16{chain_s[k]}}));
      chk($sformatf("chain_sat%0d", k), 1024'(bus.sat), 1024'({16{chain_f[k]}}));
    end
    bus.in_valid = 1'b0;
    step();
    chk("drain_valid", 1024'(bus.out_valid), 1024'(1'b0));

    // ---- backpressure: 8 random ADD beats, random out_ready ----
    m_ov = 1'b0; sent = 0; got = 0;
    va = 256'(rand_vec()); vb = 256'(rand_vec());
    for (int cyc = 0; cyc < 300 && got < 8; cyc++) begin
      bus.in_valid  = (sent < 8);
      bus.mode      = MODE_ADD;
      bus.a         = va; bus.b = vb;
      bus.out_ready = 1'($urandom_range(0, 1));
      #1;
      chk("bp_in_ready", 1024'(bus.in_ready), 1024'(!m_ov || bus.out_ready));
      chk("bp_out_valid", 1024'(bus.out_valid), 1024'(m_ov));
      if (m_ov) begin
        chk("bp_sum", 1024'(bus.sum), 1024'(q_sum[0]));
        chk("bp_sat", 1024'(bus.sat), 1024'(q_sat[0]));
      end
      out_x = m_ov && bus.out_ready;
      in_x  = bus.in_valid && (!m_ov || bus.out_ready);
      if (out_x) begin
        void'(q_sum.pop_front()); void'(q_sat.pop_front()); got++;
      end
      if (in_x) begin
        model_beat(0, 1024'(va), 1024'(vb), 16, 16, es, esat);
        q_sum.push_back(es[255:0]); q_sat.push_back(esat[15:0]);
        sent++;
        va = 256'(rand_vec()); vb = 256'(rand_vec());
      end
      m_ov = in_x ? 1'b1 : (out_x ? 1'b0 : m_ov);
      step();
    end
    chk("bp_received", 1024'(got), 1024'(8));
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;

    // ---- parameter sweep, DW=8, random mixed modes ----
    rst = 1'b1; sweep_drive(1'b0, 0, '0, '0);
    step();
    rst = 1'b0;
    foreach (m_acc[i]) m_acc[i] = 0;
    for (int n = 0; n < 60; n++) begin
      ev = ($urandom_range(0, 3) != 0);
      md = $urandom_range(0, 3);
      sa = rand_vec(); sb = rand_vec();
      sweep_drive(ev, md, sa, sb);
      if (ev) model_beat(md, sa, sb, 8, 64, es, esat);
      step();
      sweep_check("sw", ev, es, esat);
    end

    // ---- reset in the middle of an ACC chain ----
    sa = {128{8'd20}};
    sweep_drive(1'b1, 3, sa, '0);
    model_beat(3, sa, '0, 8, 64, es, esat);
    step();
    sweep_check("mid_load", 1'b1, es, esat);
    sa = {128{8'd30}};
    sweep_drive(1'b1, 2, sa, '0);
    model_beat(2, sa, '0, 8, 64, es, esat);
    step();
    sweep_check("mid_acc", 1'b1, es, esat);
    rst = 1'b1; sweep_drive(1'b0, 2, '0, '0);
    step();
    rst = 1'b0;
    sweep_check("mid_rst", 1'b0, '0, '0);
    sa = {128{8'd2}};
    sweep_drive(1'b1, 2, sa, '0);
    step();
    sweep_check("post_rst_acc", 1'b1, {128{8'd2}}, 64'd0);
    sweep_drive(1'b0, 0, '0, '0);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
